// File: rtl/gates_sweep_ctrl_if.sv
// Bus between the AND/OR gate sweep controller and its surroundings.
// Optional macro GATES_SWEEP_FAIL_IDX_EN adds the first-failure reporting signals.
interface gates_sweep_ctrl_if;
  logic       start;
  logic       busy;
  logic       done;
  logic [7:0] table_out;
  logic       pass;
  logic       gate_a;
  logic       gate_b;
  logic       gate_c;
  logic       gate_out;
`ifdef GATES_SWEEP_FAIL_IDX_EN
  logic       fail_valid;
  logic [2:0] fail_idx;
`endif

  // Requester / gate side: issues start and returns the gate output.
  modport master (
    output start,
    output gate_out,
    input  busy,
    input  done,
    input  table_out,
    input  pass,
    input  gate_a,
    input  gate_b,
    input  gate_c
`ifdef GATES_SWEEP_FAIL_IDX_EN
    ,
    input  fail_valid,
    input  fail_idx
`endif
  );

  // Controller side.
  modport slave (
    input  start,
    input  gate_out,
    output busy,
    output done,
    output table_out,
    output pass,
    output gate_a,
    output gate_b,
    output gate_c
`ifdef GATES_SWEEP_FAIL_IDX_EN
    ,
    output fail_valid,
    output fail_idx
`endif
  );
endinterface

// File: rtl/gates_sweep_ctrl.sv
// Self-test sequencer for the 3-input AND/OR select gate (c=0: a|b, c=1: a&b).
// Walks all eight {c,b,a} vectors, waits SETTLE_CYCLES per vector, captures the
// gate response into an 8-bit truth table and compares it against EXPECTED.
// Optional macro GATES_SWEEP_FAIL_IDX_EN records the index of the first mismatch.
module gates_sweep_ctrl #(
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter logic [7:0]  EXPECTED      = 8'h8E
) (
  input  logic              clk,
  input  logic              rst_n,
  gates_sweep_ctrl_if.slave bus
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned VEC_W    = 3;
  localparam bit          NO_SETTLE = (SETTLE_CYCLES == 0);
  // Counter preload; unused when there is no settle phase.
  localparam logic [CNT_W-1:0] SETTLE_LOAD =
    NO_SETTLE ? '0 : CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [VEC_W-1:0] LAST_VEC = '1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DRIVE,
    S_SETTLE,
    S_SAMPLE,
    S_FINISH
  } state_t;

  state_t           state;
  logic [VEC_W-1:0] vec_idx;
  logic [CNT_W-1:0] settle_cnt;
  logic [VEC_W-1:0] gate_q;     // {c,b,a} currently presented to the gate
  logic             busy_q;
  logic             done_q;
  logic [7:0]       table_q;
  logic             pass_q;
`ifdef GATES_SWEEP_FAIL_IDX_EN
  logic             fail_valid_q;
  logic [VEC_W-1:0] fail_idx_q;
`endif

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.table_out = table_q;
  assign bus.pass      = pass_q;
  assign bus.gate_a    = gate_q[0];
  assign bus.gate_b    = gate_q[1];
  assign bus.gate_c    = gate_q[2];
`ifdef GATES_SWEEP_FAIL_IDX_EN
  assign bus.fail_valid = fail_valid_q;
  assign bus.fail_idx   = fail_idx_q;
`endif

  // Sweep sequencer: state, vector index, settle timer and all registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      vec_idx      <= '0;
      settle_cnt   <= '0;
      gate_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      table_q      <= '0;
      pass_q       <= 1'b0;
`ifdef GATES_SWEEP_FAIL_IDX_EN
      fail_valid_q <= 1'b0;
      fail_idx_q   <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state   <= S_DRIVE;
            vec_idx <= '0;
            table_q <= '0;
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
`ifdef GATES_SWEEP_FAIL_IDX_EN
            fail_valid_q <= 1'b0;
            fail_idx_q   <= '0;
`endif
          end
        end

        S_DRIVE: begin
          gate_q <= vec_idx;
          if (NO_SETTLE) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= SETTLE_LOAD;
            state      <= S_SETTLE;
          end
        end

        S_SETTLE: begin
          if (settle_cnt == '0) begin
            state <= S_SAMPLE;
          end else begin
            settle_cnt <= settle_cnt - CNT_W'(1);
          end
        end

        S_SAMPLE: begin
          table_q[vec_idx] <= bus.gate_out;
`ifdef GATES_SWEEP_FAIL_IDX_EN
          if ((bus.gate_out != EXPECTED[vec_idx]) && !fail_valid_q) begin
            fail_valid_q <= 1'b1;
            fail_idx_q   <= vec_idx;
          end
`endif
          if (vec_idx == LAST_VEC) begin
            state <= S_FINISH;
          end else begin
            vec_idx <= vec_idx + VEC_W'(1);
            state   <= S_DRIVE;
          end
        end

        S_FINISH: begin
          done_q <= 1'b1;
          busy_q <= 1'b0;
          pass_q <= (table_q == EXPECTED);
          gate_q <= '0;
          state  <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gates_sweep_ctrl.sv
// Directed bench for gates_sweep_ctrl: three instances (settle 0, 1, 3), each
// driving a behavioural AND/OR gate model; expected sweep results are queued at
// start and compared when done pulses.
module tb_gates_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_v;
  logic [2:0] stuck;
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         done_cnt [3];

  typedef struct {
    int         d;
    logic [7:0] tbl;
    logic       ps;
    int         due;
  } exp_t;
  exp_t sb[$];

  gates_sweep_ctrl_if bus0 ();
  gates_sweep_ctrl_if bus1 ();
  gates_sweep_ctrl_if bus2 ();

  gates_sweep_ctrl #(.SETTLE_CYCLES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  gates_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  gates_sweep_ctrl #(.SETTLE_CYCLES(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic gate_fn(input logic c, input logic b, input logic a);
    return c ? (a & b) : (a | b);
  endfunction

  assign bus0.start    = start_v[0];
  assign bus1.start    = start_v[1];
  assign bus2.start    = start_v[2];
  assign bus0.gate_out = stuck[0] ? 1'b1 : gate_fn(bus0.gate_c, bus0.gate_b, bus0.gate_a);
  assign bus1.gate_out = stuck[1] ? 1'b1 : gate_fn(bus1.gate_c, bus1.gate_b, bus1.gate_a);
  assign bus2.gate_out = stuck[2] ? 1'b1 : gate_fn(bus2.gate_c, bus2.gate_b, bus2.gate_a);

  logic       done_v  [3];
  logic       busy_v  [3];
  logic       pass_v  [3];
  logic [7:0] table_v [3];
  logic [2:0] vec_v   [3];
  assign done_v[0]  = bus0.done;
  assign done_v[1]  = bus1.done;
  assign done_v[2]  = bus2.done;
  assign busy_v[0]  = bus0.busy;
  assign busy_v[1]  = bus1.busy;
  assign busy_v[2]  = bus2.busy;
  assign pass_v[0]  = bus0.pass;
  assign pass_v[1]  = bus1.pass;
  assign pass_v[2]  = bus2.pass;
  assign table_v[0] = bus0.table_out;
  assign table_v[1] = bus1.table_out;
  assign table_v[2] = bus2.table_out;
  assign vec_v[0]   = {bus0.gate_c, bus0.gate_b, bus0.gate_a};
  assign vec_v[1]   = {bus1.gate_c, bus1.gate_b, bus1.gate_a};
  assign vec_v[2]   = {bus2.gate_c, bus2.gate_b, bus2.gate_a};

  always @(posedge clk) begin
    if (done_v[0]) done_cnt[0] <= done_cnt[0] + 1;
    if (done_v[1]) done_cnt[1] <= done_cnt[1] + 1;
    if (done_v[2]) done_cnt[2] <= done_cnt[2] + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic int settle_of(input int d);
    return (d == 0) ? 0 : (d == 1) ? 1 : 3;
  endfunction

  // Pulse start for one edge and queue the expected outcome of that sweep.
  task automatic launch(input int d, input logic [7:0] tbl, input logic ps);
    exp_t e;
    int   k;
    start_v[d] = 1'b1;
    step();
    k = cyc;
    start_v[d] = 1'b0;
    chk($sformatf("busy_after_start_%0d", d), 32'(busy_v[d]), 32'd1);
    e.d   = d;
    e.tbl = tbl;
    e.ps  = ps;
    e.due = k + 1 + 8 * (2 + settle_of(d));
    sb.push_back(e);
  endtask

  // Wait for done on instance d and compare against its oldest queued entry.
  task automatic wait_done(input int d);
    int   idx = -1;
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < sb.size(); i++)
      if (sb[i].d == d && idx < 0) idx = i;
    for (int n = 0; n < 300 && !seen; n++) begin
      if (done_v[d]) seen = 1'b1;
      else step();
    end
    if (!seen || idx < 0) begin
      chk($sformatf("done_timeout_%0d", d), 32'(seen && idx >= 0), 32'd1);
    end else begin
      e = sb[idx];
      sb.delete(idx);
      chk($sformatf("done_edge_%0d", d), 32'(cyc), 32'(e.due));
      chk($sformatf("table_%0d", d), 32'(table_v[d]), 32'(e.tbl));
      chk($sformatf("pass_%0d", d), 32'(pass_v[d]), 32'(e.ps));
      chk($sformatf("busy_at_done_%0d", d), 32'(busy_v[d]), 32'd0);
      chk($sformatf("gates_at_done_%0d", d), 32'(vec_v[d]), 32'd0);
      step();
      chk($sformatf("done_one_cycle_%0d", d), 32'(done_v[d]), 32'd0);
    end
  endtask

  initial begin
    int c0;
    rst_n   = 1'b0;
    start_v = '0;
    stuck   = '0;

    // Reset and idle
    step();
    chk("reset_outs", 32'({busy_v[1], done_v[1], table_v[1], pass_v[1], vec_v[1]}), 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("idle_outs", 32'({busy_v[1], done_v[1], table_v[1], pass_v[1], vec_v[1]}), 32'd0);
      chk("idle_busy_all", 32'({busy_v[0], busy_v[2]}), 32'd0);
    end

    // Golden sweep with vector trace: each vector held 3 cycles
    launch(1, 8'h8E, 1'b1);
    for (int j = 0; j < 24; j++) begin
      step();
      chk($sformatf("vec_trace_%0d", j), 32'(vec_v[1]), 32'(j / 3));
    end
    wait_done(1);
`ifdef GATES_SWEEP_FAIL_IDX_EN
    chk("fail_valid_golden", 32'(bus1.fail_valid), 32'd0);
`endif
    repeat (5) step();
    chk("table_hold", 32'(table_v[1]), 32'h8E);
    chk("pass_hold", 32'(pass_v[1]), 32'd1);

    // Stuck-at-1 gate
    stuck[1] = 1'b1;
    launch(1, 8'hFF, 1'b0);
    wait_done(1);
`ifdef GATES_SWEEP_FAIL_IDX_EN
    chk("fail_valid_fault", 32'(bus1.fail_valid), 32'd1);
    chk("fail_idx_fault", 32'(bus1.fail_idx), 32'd0);
`endif
    stuck[1] = 1'b0;
    step();

    // Start pulses while busy are ignored
    c0 = done_cnt[1];
    launch(1, 8'h8E, 1'b1);
    repeat (4) step();
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    repeat (6) step();
    start_v[1] = 1'b1;
    step();
    start_v[1] = 1'b0;
    wait_done(1);
    repeat (5) step();
    chk("single_done", 32'(done_cnt[1] - c0), 32'd1);
    chk("no_relaunch", 32'(busy_v[1]), 32'd0);

    // Reset during vector 4
    launch(1, 8'h8E, 1'b1);
    repeat (13) step();
    chk("vec4_before_reset", 32'(vec_v[1]), 32'd4);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_reset_outs", 32'({busy_v[1], done_v[1], table_v[1], pass_v[1], vec_v[1]}), 32'd0);
    sb.delete();
    c0 = done_cnt[1];
    repeat (40) step();
    chk("no_done_after_reset", 32'(done_cnt[1] - c0), 32'd0);
    chk("idle_after_reset", 32'(busy_v[1]), 32'd0);
    launch(1, 8'h8E, 1'b1);
    wait_done(1);

    // Settle 0 and settle 3 instances
    launch(0, 8'h8E, 1'b1);
    launch(2, 8'h8E, 1'b1);
    wait_done(0);
    wait_done(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
